// File: rtl/register_read_module.sv
// Single-request register read port with an R15 (PC+8) path and write-collision handling.
// REGISTER_READ_BYPASS_EN: when defined, a colliding write is forwarded instead of re-reading the bank.
module register_read_module #(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned ADDR_SIZE = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 REQ_VALID,
  input  logic [ADDR_SIZE-1:0] REQ_ADDR,
  output logic                 REQ_READY,
  output logic [ADDR_SIZE-1:0] BANK_ADDR,
  input  logic [DATA_SIZE-1:0] BANK_DATA,
  input  logic [DATA_SIZE-1:0] PC_IN,
  input  logic                 WR_EN,
  input  logic [ADDR_SIZE-1:0] WR_ADDR,
  input  logic [DATA_SIZE-1:0] WR_DATA,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [DATA_SIZE-1:0] OUT_DATA
);

  localparam int unsigned PC_OFFSET = 8;
  localparam logic [ADDR_SIZE-1:0] PC_IDX = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_SIZE-1:0]   idx_q, idx_d;
  logic                   out_valid_q, out_valid_d;
  logic [DATA_SIZE-1:0]   out_data_q, out_data_d;

  logic                   is_pc_c;
  logic                   collision_c;
  logic                   accept_c;
  logic [DATA_SIZE-1:0]   pc_plus_c;

  assign is_pc_c     = (idx_q == PC_IDX);
  assign collision_c = WR_EN && (WR_ADDR == idx_q) && !is_pc_c;
  assign pc_plus_c   = PC_IN + DATA_SIZE'(PC_OFFSET);
  assign accept_c    = (state_q == ST_IDLE) && REQ_VALID && !RST;

  // The bank has one cycle of read latency, so the index is presented in the accepting cycle.
  assign REQ_READY = (state_q == ST_IDLE) && !RST;
  assign BANK_ADDR = accept_c ? REQ_ADDR : idx_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = out_data_q;

`ifndef REGISTER_READ_BYPASS_EN
  logic unused_wr_data;
  assign unused_wr_data = ^WR_DATA;
`endif

  // Next-state and datapath
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      ST_IDLE: begin
        if (REQ_VALID) begin
          idx_d   = REQ_ADDR;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
`ifdef REGISTER_READ_BYPASS_EN
        if (is_pc_c) begin
          out_data_d = pc_plus_c;
        end else if (collision_c) begin
          out_data_d = WR_DATA;
        end else begin
          out_data_d = BANK_DATA;
        end
        out_valid_d = 1'b1;
        state_d     = ST_HOLD;
`else
        // A colliding write lands in the bank this edge; stay and read it next cycle.
        if (!collision_c) begin
          out_data_d  = is_pc_c ? pc_plus_c : BANK_DATA;
          out_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end
`endif
      end
      ST_HOLD: begin
        if (OUT_READY) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_register_read_module.sv
// Bench for register_read_module: write-first bank model, scoreboard of expected read results.
module tb_register_read_module;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;

`ifdef REGISTER_READ_BYPASS_EN
  localparam int LAT_COLL1 = 2;
  localparam int LAT_COLL2 = 2;
  localparam bit COLL2_LAST = 1'b0;
`else
  localparam int LAT_COLL1 = 3;
  localparam int LAT_COLL2 = 4;
  localparam bit COLL2_LAST = 1'b1;
`endif

  logic          CLK = 1'b0;
  logic          RST;
  logic          REQ_VALID;
  logic [AW-1:0] REQ_ADDR;
  logic          REQ_READY;
  logic [AW-1:0] BANK_ADDR;
  logic [DW-1:0] bank_rd;
  logic [DW-1:0] PC_IN;
  logic          WR_EN;
  logic [AW-1:0] WR_ADDR;
  logic [DW-1:0] WR_DATA;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic [DW-1:0] OUT_DATA;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] sb[$];
  logic [DW-1:0] bank[16];

  always #5 CLK = ~CLK;

  register_read_module #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) dut (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_ADDR(REQ_ADDR),
    .REQ_READY(REQ_READY), .BANK_ADDR(BANK_ADDR), .BANK_DATA(bank_rd),
    .PC_IN(PC_IN), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA)
  );

  // Synchronous-read bank, write-first on same-address read/write
  always @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 16; i++)
        bank[i] <= (i == 3) ? 32'h1234_5678 : {8'(i), 24'hC0FFEE};
      bank_rd <= '0;
    end else begin
      if (WR_EN) bank[WR_ADDR] <= WR_DATA;
      bank_rd <= (WR_EN && WR_ADDR == BANK_ADDR) ? WR_DATA : bank[BANK_ADDR];
    end
  end

  task automatic issue(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    REQ_VALID = 1'b1;
    REQ_ADDR  = a;
    sb.push_back(exp);
    @(negedge CLK);
    REQ_VALID = 1'b0;
  endtask

  // Called one cycle after acceptance; drives ncoll cycles of writes to a, returns latency or -1.
  task automatic wait_out(input int ncoll, input logic [AW-1:0] a,
                          input logic [DW-1:0] d0, input logic [DW-1:0] d1, output int lat);
    lat = 1;
    if (ncoll > 0) begin
      WR_EN = 1'b1; WR_ADDR = a; WR_DATA = d0;
    end
    while (!OUT_VALID && lat < 12) begin
      @(negedge CLK);
      lat++;
      if (lat - 1 < ncoll) WR_DATA = d1;
      else WR_EN = 1'b0;
    end
    WR_EN = 1'b0;
    if (!OUT_VALID) lat = -1;
  endtask

  task automatic consume;
    OUT_READY = 1'b1;
    @(negedge CLK);
    OUT_READY = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b1; REQ_VALID = 1'b1; REQ_ADDR = 4'd9; PC_IN = '0;
    WR_EN = 1'b0; WR_ADDR = '0; WR_DATA = '0; OUT_READY = 1'b0;
    repeat (2) @(negedge CLK);
    checks++; if (REQ_READY !== 1'b0) begin failures++; $display("FAIL rst_req_ready got=%b exp=0", REQ_READY); end
    checks++; if (OUT_VALID !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", OUT_VALID); end
    checks++; if (OUT_DATA !== 32'h0) begin failures++; $display("FAIL rst_out_data got=%h exp=0", OUT_DATA); end
    checks++; if (BANK_ADDR !== 4'd0) begin failures++; $display("FAIL rst_bank_addr got=%h exp=0", BANK_ADDR); end
    RST = 1'b0; REQ_VALID = 1'b0;
    #1;
    checks++; if (REQ_READY !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%b exp=1", REQ_READY); end
    @(negedge CLK);
  endtask

  task automatic test_basic_read;
    int lat;
    logic [DW-1:0] exp;
    checks++; if (REQ_READY !== 1'b1) begin failures++; $display("FAIL basic_ready got=%b exp=1", REQ_READY); end
    issue(4'd3, 32'h1234_5678);
    checks++; if (BANK_ADDR !== 4'd3) begin failures++; $display("FAIL basic_fetch_addr got=%h exp=3", BANK_ADDR); end
    checks++; if (REQ_READY !== 1'b0) begin failures++; $display("FAIL basic_fetch_ready got=%b exp=0", REQ_READY); end
    wait_out(0, 4'd0, '0, '0, lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL basic_latency got=%0d exp=2", lat); end
    checks++;
    if (sb.size() == 0) begin failures++; $display("FAIL basic_data got=%h exp=<none queued>", OUT_DATA); end
    else begin
      exp = sb.pop_front();
      if (OUT_DATA !== exp) begin failures++; $display("FAIL basic_data got=%h exp=%h", OUT_DATA, exp); end
    end
    checks++; if (BANK_ADDR !== 4'd3) begin failures++; $display("FAIL basic_hold_addr got=%h exp=3", BANK_ADDR); end
    consume();
    checks++; if (OUT_VALID !== 1'b0) begin failures++; $display("FAIL basic_drop_valid got=%b exp=0", OUT_VALID); end
    checks++; if (REQ_READY !== 1'b1) begin failures++; $display("FAIL basic_back_idle got=%b exp=1", REQ_READY); end
  endtask

  task automatic test_pc_read;
    int lat;
    logic [DW-1:0] exp;
    logic [DW-1:0] pcs[2];
    logic [DW-1:0] exps[2];
    pcs[0] = 32'hFFFF_FFFC; exps[0] = 32'h0000_0004;
    pcs[1] = 32'h0000_1000; exps[1] = 32'h0000_1008;
    for (int k = 0; k < 2; k++) begin
      PC_IN = pcs[k];
      issue(4'd15, exps[k]);
      wait_out(1, 4'd15, 32'hDEAD_BEEF, 32'h0, lat);
      checks++; if (lat !== 2) begin failures++; $display("FAIL pc_latency[%0d] got=%0d exp=2", k, lat); end
      checks++;
      if (sb.size() == 0) begin failures++; $display("FAIL pc_data[%0d] got=%h exp=<none queued>", k, OUT_DATA); end
      else begin
        exp = sb.pop_front();
        if (OUT_DATA !== exp) begin failures++; $display("FAIL pc_data[%0d] got=%h exp=%h", k, OUT_DATA, exp); end
      end
      consume();
    end
  endtask

  task automatic test_collision;
    int lat;
    logic [DW-1:0] exp;
    // write to a different index during FETCH
    issue(4'd5, bank[5]);
    wait_out(1, 4'd6, 32'h6666_6666, 32'h0, lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL other_wr_latency got=%0d exp=2", lat); end
    checks++;
    if (sb.size() == 0) begin failures++; $display("FAIL other_wr_data got=%h exp=<none queued>", OUT_DATA); end
    else begin
      exp = sb.pop_front();
      if (OUT_DATA !== exp) begin failures++; $display("FAIL other_wr_data got=%h exp=%h", OUT_DATA, exp); end
    end
    consume();
    // single-cycle collision
    issue(4'd5, 32'hA5A5_A5A5);
    wait_out(1, 4'd5, 32'hA5A5_A5A5, 32'h0, lat);
    checks++; if (lat !== LAT_COLL1) begin failures++; $display("FAIL coll1_latency got=%0d exp=%0d", lat, LAT_COLL1); end
    checks++;
    if (sb.size() == 0) begin failures++; $display("FAIL coll1_data got=%h exp=<none queued>", OUT_DATA); end
    else begin
      exp = sb.pop_front();
      if (OUT_DATA !== exp) begin failures++; $display("FAIL coll1_data got=%h exp=%h", OUT_DATA, exp); end
    end
    consume();
    // two back-to-back colliding writes
    issue(4'd5, COLL2_LAST ? 32'h3333_4444 : 32'h1111_2222);
    wait_out(2, 4'd5, 32'h1111_2222, 32'h3333_4444, lat);
    checks++; if (lat !== LAT_COLL2) begin failures++; $display("FAIL coll2_latency got=%0d exp=%0d", lat, LAT_COLL2); end
    checks++;
    if (sb.size() == 0) begin failures++; $display("FAIL coll2_data got=%h exp=<none queued>", OUT_DATA); end
    else begin
      exp = sb.pop_front();
      if (OUT_DATA !== exp) begin failures++; $display("FAIL coll2_data got=%h exp=%h", OUT_DATA, exp); end
    end
    consume();
  endtask

  task automatic test_hold;
    int lat;
    logic [DW-1:0] exp;
    logic [DW-1:0] held;
    held = bank[5];
    issue(4'd5, held);
    wait_out(0, 4'd0, '0, '0, lat);
    checks++;
    if (sb.size() == 0) begin failures++; $display("FAIL hold_data got=%h exp=<none queued>", OUT_DATA); end
    else begin
      exp = sb.pop_front();
      if (OUT_DATA !== exp) begin failures++; $display("FAIL hold_data got=%h exp=%h", OUT_DATA, exp); end
    end
    for (int k = 0; k < 4; k++) begin
      WR_EN = 1'b1; WR_ADDR = 4'd5; WR_DATA = $urandom;
      REQ_VALID = ~REQ_VALID; REQ_ADDR = 4'd2;
      @(negedge CLK);
      checks++; if (OUT_DATA !== held) begin failures++; $display("FAIL hold_stable[%0d] got=%h exp=%h", k, OUT_DATA, held); end
      checks++; if (OUT_VALID !== 1'b1) begin failures++; $display("FAIL hold_valid[%0d] got=%b exp=1", k, OUT_VALID); end
      checks++; if (REQ_READY !== 1'b0) begin failures++; $display("FAIL hold_ready[%0d] got=%b exp=0", k, REQ_READY); end
    end
    WR_EN = 1'b0;
    OUT_READY = 1'b1; REQ_VALID = 1'b1; REQ_ADDR = 4'd2;
    @(negedge CLK);
    OUT_READY = 1'b0; REQ_VALID = 1'b0;
    checks++; if (OUT_VALID !== 1'b0) begin failures++; $display("FAIL hold_release_valid got=%b exp=0", OUT_VALID); end
    checks++; if (REQ_READY !== 1'b1) begin failures++; $display("FAIL hold_req_ignored got=%b exp=1", REQ_READY); end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [DW-1:0] exp;
    logic [AW-1:0] a;
    OUT_READY = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = AW'(8 + k);
      checks++; if (REQ_READY !== 1'b1) begin failures++; $display("FAIL b2b_ready[%0d] got=%b exp=1", k, REQ_READY); end
      issue(a, bank[a]);
      wait_out(0, 4'd0, '0, '0, lat);
      checks++; if (lat !== 2) begin failures++; $display("FAIL b2b_latency[%0d] got=%0d exp=2", k, lat); end
      checks++;
      if (sb.size() == 0) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=<none queued>", k, OUT_DATA); end
      else begin
        exp = sb.pop_front();
        if (OUT_DATA !== exp) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", k, OUT_DATA, exp); end
      end
      @(negedge CLK);
    end
    OUT_READY = 1'b0;
  endtask

  task automatic test_reset_abort;
    int lat;
    logic [DW-1:0] exp;
    // abort during FETCH
    issue(4'd4, bank[4]);
    void'(sb.pop_back());
    RST = 1'b1;
    @(negedge CLK);
    checks++; if (OUT_VALID !== 1'b0) begin failures++; $display("FAIL abort_fetch_valid got=%b exp=0", OUT_VALID); end
    checks++; if (REQ_READY !== 1'b0) begin failures++; $display("FAIL abort_fetch_ready got=%b exp=0", REQ_READY); end
    RST = 1'b0;
    @(negedge CLK);
    checks++; if (OUT_VALID !== 1'b0) begin failures++; $display("FAIL abort_fetch_late got=%b exp=0", OUT_VALID); end
    // abort during HOLD
    issue(4'd6, bank[6]);
    wait_out(0, 4'd0, '0, '0, lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL abort_hold_latency got=%0d exp=2", lat); end
    checks++;
    if (sb.size() == 0) begin failures++; $display("FAIL abort_hold_data got=%h exp=<none queued>", OUT_DATA); end
    else begin
      exp = sb.pop_front();
      if (OUT_DATA !== exp) begin failures++; $display("FAIL abort_hold_data got=%h exp=%h", OUT_DATA, exp); end
    end
    RST = 1'b1;
    @(negedge CLK);
    checks++; if (OUT_VALID !== 1'b0) begin failures++; $display("FAIL abort_hold_valid got=%b exp=0", OUT_VALID); end
    checks++; if (OUT_DATA !== 32'h0) begin failures++; $display("FAIL abort_hold_outdata got=%h exp=0", OUT_DATA); end
    checks++; if (REQ_READY !== 1'b0) begin failures++; $display("FAIL abort_hold_ready got=%b exp=0", REQ_READY); end
    RST = 1'b0;
    #1;
    checks++; if (REQ_READY !== 1'b1) begin failures++; $display("FAIL abort_release_ready got=%b exp=1", REQ_READY); end
    @(negedge CLK);
    checks++; if (OUT_VALID !== 1'b0) begin failures++; $display("FAIL abort_hold_late got=%b exp=0", OUT_VALID); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_read();
    test_pc_read();
    test_collision();
    test_hold();
    test_back_to_back();
    test_reset_abort();
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL sb_drained got=%0d exp=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/register_read_module.md
REGISTER_READ_MODULE -- requirements
Module: register_read_module

Interface
REQ-001 Parameter DATA_SIZE, default 32, SHALL set the register data width.
REQ-002 Parameter ADDR_SIZE, default 4, SHALL set the register index width; index 2**ADDR_SIZE-1 is the PC register (R15).
REQ-003 CLK  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 RST  input  1  reset; synchronous and active-high.
REQ-005 REQ_VALID  input  1  read request present.
REQ-006 REQ_ADDR  input  ADDR_SIZE  register index to read.
REQ-007 REQ_READY  output  1  block accepts a request this cycle.
REQ-008 BANK_ADDR  output  ADDR_SIZE  index driven to the register bank.
REQ-009 BANK_DATA  input  DATA_SIZE  bank read data, valid one cycle after BANK_ADDR.
REQ-010 PC_IN  input  DATA_SIZE  current instruction address.
REQ-011 WR_EN, WR_ADDR, WR_DATA  input  1/ADDR_SIZE/DATA_SIZE  snooped bank write port.
REQ-012 OUT_VALID  output  1  OUT_DATA holds a completed read.
REQ-013 OUT_READY  input  1  consumer accepts OUT_DATA.
REQ-014 OUT_DATA  output  DATA_SIZE  read result.

Function
REQ-015 The block SHALL implement the FSM states IDLE, FETCH and HOLD.
REQ-016 REQ_READY SHALL be 1 only in IDLE and only while RST=0.
REQ-017 In IDLE with REQ_VALID=1, the block SHALL latch REQ_ADDR, drive it on BANK_ADDR and go to FETCH next cycle.
REQ-018 BANK_ADDR SHALL hold the latched index throughout FETCH and HOLD.
REQ-019 In FETCH, OUT_DATA SHALL capture BANK_DATA, OUT_VALID SHALL rise on the next edge, and the FSM SHALL go to HOLD.
REQ-020 If the latched index is R15, FETCH SHALL capture PC_IN+8 modulo 2**DATA_SIZE instead of BANK_DATA; R15 SHALL never stall or bypass.
REQ-021 In HOLD, OUT_DATA and OUT_VALID SHALL stay stable until OUT_READY=1; snooped writes SHALL NOT alter OUT_DATA.
REQ-022 In HOLD with OUT_READY=1, OUT_VALID SHALL drop on the next edge and the FSM SHALL go to IDLE; REQ_VALID in that cycle SHALL be ignored.
REQ-023 Request-to-OUT_VALID latency SHALL be 2 cycles with no collision; peak throughput SHALL be one read per 3 cycles.
REQ-024 A collision SHALL be defined as FETCH with WR_EN=1 and WR_ADDR equal to the latched non-R15 index.
REQ-025 Writes to other indices, and writes in IDLE or HOLD, SHALL have no effect on block state.

Reset
REQ-026 RST=1 at an edge SHALL force: state IDLE, OUT_VALID=0, OUT_DATA=0, BANK_ADDR=0, latched index=0.
REQ-027 REQ_READY SHALL be 0 while RST=1 and 1 from the first cycle after RST is released.
REQ-028 RST asserted in FETCH or HOLD SHALL abort the read with no OUT_VALID pulse.

Configuration
REQ-029 Macro REGISTER_READ_BYPASS_EN SHALL select collision handling.
REQ-030 With REGISTER_READ_BYPASS_EN defined, a collision in FETCH SHALL capture WR_DATA instead of BANK_DATA, with no added latency.
REQ-031 With REGISTER_READ_BYPASS_EN undefined, a collision SHALL keep the FSM in FETCH for one more cycle to re-read the bank, and SHALL repeat while collisions persist.

Verification
REQ-032 Reset, then REQ_ADDR=3 with BANK_DATA=0x1234_5678 -> OUT_VALID=1 two cycles after acceptance and OUT_DATA=0x1234_5678.
REQ-033 Read R15 with PC_IN=0xFFFF_FFFC -> OUT_DATA=0x0000_0004 (wrap-around).
REQ-034 Read index 5, with WR_EN=1, WR_ADDR=5, WR_DATA=0xA5A5_A5A5 during FETCH -> bypass build returns 0xA5A5_A5A5 at latency 2; non-bypass build returns the re-read BANK_DATA at latency 3.
REQ-035 Hold OUT_READY=0 for 4 cycles, writing index 5 and toggling REQ_VALID -> OUT_DATA unchanged, REQ_READY=0; OUT_READY=1 -> IDLE next cycle.
REQ-036 Assert RST in HOLD with OUT_VALID=1 -> OUT_VALID=0 and OUT_DATA=0 next cycle, REQ_READY=1 the cycle after RST is released.
